// File: rtl/spi_slave_bmm150_model.sv
// -----------------------------------------------------------------------------
// spi_slave_bmm150_model
//
// Synthesizable SPI responder that behaves like the BMM150 register interface,
// so the BMM150 SPI master can be looped back on the FPGA without the sensor.
// SCLK/CS_N/MOSI are oversampled in the clk domain. Each frame is RW + 7-bit
// address + 8-bit data, MSB first, in SPI mode 3. Reads are served from a
// 128x8 register file and continue as a burst with an auto-incrementing
// address. Writes are committed and reported on the wr_* port. A local port
// injects magnetometer samples into registers 0x42..0x49.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   sclk       SPI clock from master (mode 3, idles high)
//   cs_n       SPI chip select, active low
//   mosi       SPI data from master
//   miso       SPI data to master (1 when not driving read data)
//   meas_load  1-cycle pulse: load meas_data into regs 0x42..0x49
//   meas_data  byte k (bits 8k+7:8k) goes to reg 0x42+k
//   wr_valid   1-cycle pulse: SPI write committed
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   frame_err  1-cycle pulse: cs_n rose in the middle of a byte
//   busy       synchronized cs_n is low
//
// The SCLK half-period must be at least SYNC_STAGES+2 clk cycles.
// -----------------------------------------------------------------------------
module spi_slave_bmm150_model #(
  parameter logic [7:0] CHIP_ID     = 8'h32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        meas_load,
  input  logic [63:0] meas_data,
  output logic        wr_valid,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } state_t;

  localparam logic [6:0] CHIP_ID_ADDR = 7'h40;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  // Reset values match the bus idle levels so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b1;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [2:0]  bit_cnt_q;     // bit position within the current byte
  logic [6:0]  rx_q;          // first 7 received bits of the current byte
  logic [6:0]  tx_q;          // remaining read bits still to be shifted out
  logic        tx_loaded_q;   // current read byte has been snapshotted
  logic        rw_q;
  logic [6:0]  addr_q;
  logic        miso_q;
  logic        wr_valid_q;
  logic [6:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        frame_err_q;

  logic [7:0]  rx_byte_d;     // complete byte including the bit sampled now
  logic [7:0]  rd_byte_d;
  logic        commit_d;

  logic [7:0]  regs_q [128];

  assign rx_byte_d = {rx_q, mosi_s};
  assign rd_byte_d = (addr_q == CHIP_ID_ADDR) ? CHIP_ID : regs_q[addr_q];
  // A write commits on the 8th data rise; a simultaneous cs_n rise aborts it.
  assign commit_d  = (state_q == ST_DATA) && !rw_q && sclk_rise &&
                     (bit_cnt_q == 3'd7) && !cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 7'd0;
      tx_loaded_q <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      miso_q      <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (cs_rise) begin
        // End of frame from any state; a nonzero bit count means a cut byte.
        state_q     <= ST_IDLE;
        miso_q      <= 1'b1;
        bit_cnt_q   <= 3'd0;
        tx_loaded_q <= 1'b0;
        frame_err_q <= (bit_cnt_q != 3'd0);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx_q      <= rx_byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rw_q        <= rx_q[6];
                addr_q      <= rx_byte_d[6:0];
                tx_loaded_q <= 1'b0;
                state_q     <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              rx_q      <= rx_byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rw_q) begin
                  // Burst read: advance (7-bit wrap) and snapshot on next fall.
                  addr_q      <= addr_q + 7'd1;
                  tx_loaded_q <= 1'b0;
                end else begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= rx_byte_d;
                  state_q    <= ST_HOLD;
                end
              end
            end else if (sclk_fall && rw_q) begin
              if (!tx_loaded_q) begin
                tx_q        <= rd_byte_d[6:0];
                miso_q      <= rd_byte_d[7];
                tx_loaded_q <= 1'b1;
              end else begin
                miso_q <= tx_q[6];
                tx_q   <= {tx_q[5:0], 1'b0};
              end
            end
          end
          ST_HOLD: begin
            // Wait for cs_n to rise; sclk is ignored.
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The SPI commit is checked first so it wins over meas_load
  // on the same address in the same cycle. Entry 0x40 is never written; reads
  // of that address return CHIP_ID.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 128; gi++) begin : g_reg
    if (gi == 'h40) begin : g_id
      always_ff @(posedge clk) begin
        regs_q[gi] <= 8'h00;
      end
    end else if (gi >= 'h42 && gi <= 'h49) begin : g_meas
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[gi] <= 8'h00;
        end else if (commit_d && addr_q == 7'(gi)) begin
          regs_q[gi] <= rx_byte_d;
        end else if (meas_load) begin
          regs_q[gi] <= meas_data[8*(gi-'h42) +: 8];
        end
      end
    end else begin : g_plain
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[gi] <= 8'h00;
        end else if (commit_d && addr_q == 7'(gi)) begin
          regs_q[gi] <= rx_byte_d;
        end
      end
    end
  end

  assign miso      = miso_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign busy      = ~cs_s;

endmodule
